// File: rtl/boss_sprite_ctrl.sv
// Boss/enemy sprite controller on the system clock with an internal tick strobe.
// Ports: Clk, Reset/dead_reset (sync, active-high, equivalent), keycode (4 key bytes),
// BG_step (scroll position), DrawX/DrawY (current pixel), hit (contact pulse);
// outputs is_sprite/sprite_addr (combinational pixel test and ROM address),
// sprite_x/sprite_y (top-left), active, hp, defeated.
module boss_sprite_ctrl #(
  parameter int unsigned X_HOME      = 370,
  parameter int unsigned Y_HOME      = 290,
  parameter int unsigned SIZE_X      = 130,
  parameter int unsigned SIZE_Y      = 130,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned ROM_X_OFF   = 123,
  parameter int unsigned ROM_STRIDE  = 188,
  parameter int unsigned TICK_DIV    = 6_000_000,
  parameter int unsigned APPEAR_MIN  = 280,
  parameter int unsigned APPEAR_MAX  = 360,
  parameter int unsigned SCROLL_LO   = 270,
  parameter int unsigned SCROLL_HI   = 320,
  parameter int unsigned SCROLL_STEP = 80,
  parameter int unsigned DROP        = 20,
  parameter int unsigned HP_INIT     = 3,
  parameter int unsigned FLASH_TICKS = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        dead_reset,
  input  logic [31:0] keycode,
  input  logic [8:0]  BG_step,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        hit,
  output logic        is_sprite,
  output logic [18:0] sprite_addr,
  output logic [9:0]  sprite_x,
  output logic [9:0]  sprite_y,
  output logic        active,
  output logic [3:0]  hp,
  output logic        defeated
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;

  localparam logic [9:0]  LP_XH      = 10'(X_HOME);
  localparam logic [9:0]  LP_YH      = 10'(Y_HOME);
  localparam logic [9:0]  LP_YENTER  = 10'(Y_HOME - DROP);
  localparam logic [9:0]  LP_DROP    = 10'(DROP);
  localparam logic [9:0]  LP_SX      = 10'(SIZE_X);
  localparam logic [9:0]  LP_SY      = 10'(SIZE_Y);
  localparam logic [9:0]  LP_AMIN    = 10'(APPEAR_MIN);
  localparam logic [9:0]  LP_AMAX    = 10'(APPEAR_MAX);
  localparam logic [9:0]  LP_SLO     = 10'(SCROLL_LO);
  localparam logic [9:0]  LP_SHI     = 10'(SCROLL_HI);
  localparam logic [9:0]  LP_STEP    = 10'(SCROLL_STEP);
  localparam logic [18:0] LP_ROFF    = 19'(ROM_X_OFF);
  localparam logic [18:0] LP_STRIDE  = 19'(ROM_STRIDE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER,
    S_PATROL,
    S_FLASH,
    S_DEFEATED
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [FW-1:0] r_flash;
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic [2:0]    r_step;
  logic [3:0]    r_hp;
  logic          r_active;
  logic          r_defeated;
  logic          r_hit_lat;

  logic          w_tick;
  logic          w_left;
  logic          w_right;
  logic          w_in_scroll;
  logic [9:0]    w_scroll;
  logic [9:0]    w_bg;
  logic          w_appear;
  logic          w_retreat;
  logic          w_hit_now;
  logic [3:0]    w_hp_dec;
  logic [9:0]    w_x_move;
  logic [9:0]    w_dx;
  logic [9:0]    w_dy;
  logic [9:0]    w_ax;
  logic [9:0]    w_ay;
  logic          w_on;

  function automatic logic [9:0] pat_offset(input logic [2:0] s);
    case (s)
      3'd0:    pat_offset = 10'(-36);
      3'd1:    pat_offset = 10'd0;
      3'd2:    pat_offset = 10'd16;
      3'd3:    pat_offset = 10'(-48);
      3'd4:    pat_offset = 10'd36;
      3'd5:    pat_offset = 10'd0;
      3'd6:    pat_offset = 10'(-16);
      default: pat_offset = 10'd48;
    endcase
  endfunction

  assign w_tick = (r_cnt == CW'(TICK_DIV - 1));

  always_comb begin
    w_left  = 1'b0;
    w_right = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (keycode[8*i +: 8] == 8'h04) w_left  = 1'b1;
      if (keycode[8*i +: 8] == 8'h07) w_right = 1'b1;
    end
  end

  assign w_bg        = {1'b0, BG_step};
  assign w_in_scroll = (w_bg >= LP_SLO) && (w_bg <= LP_SHI);
  assign w_scroll    = (w_in_scroll && w_left && !w_right) ? LP_STEP :
                       (w_in_scroll && w_right && !w_left) ? -LP_STEP : '0;
  assign w_appear    = (w_bg > LP_AMIN) && (w_bg < LP_AMAX);
  assign w_retreat   = (w_bg > LP_AMAX);
  // A hit coinciding with the tick counts as if it had been latched earlier.
  assign w_hit_now   = r_hit_lat | (hit & (r_state == S_PATROL));
  assign w_hp_dec    = r_hp - 4'd1;
  assign w_x_move    = r_x + pat_offset(r_step) + w_scroll;

  always_ff @(posedge Clk) begin
    if (Reset || dead_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_flash    <= '0;
      r_x        <= LP_XH;
      r_y        <= LP_YH;
      r_step     <= '0;
      r_hp       <= 4'(HP_INIT);
      r_active   <= 1'b0;
      r_defeated <= 1'b0;
      r_hit_lat  <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);

      if (w_tick)
        r_hit_lat <= 1'b0;
      else if (hit && (r_state == S_PATROL))
        r_hit_lat <= 1'b1;

      if (w_tick) begin
        case (r_state)
          S_IDLE: begin
            if (w_appear) begin
              r_state  <= S_ENTER;
              r_y      <= LP_YENTER;
              r_active <= 1'b1;
            end
          end
          S_ENTER: begin
            if (w_retreat) begin
              r_state  <= S_IDLE;
              r_x      <= LP_XH;
              r_y      <= LP_YH;
              r_active <= 1'b0;
            end else begin
              r_state <= S_PATROL;
              r_y     <= r_y + LP_DROP;
              r_x     <= r_x + w_scroll;
              r_step  <= '0;
            end
          end
          S_PATROL: begin
            if (w_retreat) begin
              r_state  <= S_IDLE;
              r_x      <= LP_XH;
              r_y      <= LP_YH;
              r_active <= 1'b0;
            end else begin
              r_x    <= w_x_move;
              r_step <= r_step + 3'd1;
              if (w_hit_now) begin
                r_hp     <= w_hp_dec;
                r_active <= 1'b0;
                r_flash  <= '0;
                if (w_hp_dec == 4'd0) begin
                  r_state    <= S_DEFEATED;
                  r_defeated <= 1'b1;
                end else begin
                  r_state <= S_FLASH;
                end
              end
            end
          end
          S_FLASH: begin
            if (w_retreat) begin
              r_state  <= S_IDLE;
              r_x      <= LP_XH;
              r_y      <= LP_YH;
              r_active <= 1'b0;
            end else begin
              r_x    <= w_x_move;
              r_step <= r_step + 3'd1;
              // The entry tick already showed the first (dark) phase.
              if (r_flash == FW'(FLASH_TICKS - 1)) begin
                r_state  <= S_PATROL;
                r_active <= 1'b1;
              end else begin
                r_flash  <= r_flash + FW'(1);
                r_active <= ~r_active;
              end
            end
          end
          S_DEFEATED: begin
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign w_dx = DrawX - r_x;
  assign w_dy = DrawY - r_y;
  assign w_ax = w_dx >> SCALE_SHIFT;
  assign w_ay = w_dy >> SCALE_SHIFT;
  assign w_on = r_active && (DrawX >= r_x) && (DrawY >= r_y) &&
                (w_dx < LP_SX) && (w_dy < LP_SY);

  assign is_sprite   = w_on;
  assign sprite_addr = w_on ? (19'(w_ax) + LP_ROFF + 19'(w_ay) * LP_STRIDE) : '0;
  assign sprite_x    = r_x;
  assign sprite_y    = r_y;
  assign active      = r_active;
  assign hp          = r_hp;
  assign defeated    = r_defeated;

endmodule

// File: tb/tb_boss_sprite_ctrl.sv
module tb_boss_sprite_ctrl;

  localparam int TD = 4;
  localparam int FL = 4;
  localparam int HP0 = 3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        dead_reset = 1'b0;
  logic [31:0] keycode = '0;
  logic [8:0]  BG_step = '0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        hit = 1'b0;
  logic        is_sprite;
  logic [18:0] sprite_addr;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic        active;
  logic [3:0]  hp;
  logic        defeated;

  always #5 Clk = ~Clk;

  boss_sprite_ctrl #(.TICK_DIV(TD), .HP_INIT(HP0), .FLASH_TICKS(FL)) dut (
    .Clk(Clk), .Reset(Reset), .dead_reset(dead_reset), .keycode(keycode),
    .BG_step(BG_step), .DrawX(DrawX), .DrawY(DrawY), .hit(hit),
    .is_sprite(is_sprite), .sprite_addr(sprite_addr), .sprite_x(sprite_x),
    .sprite_y(sprite_y), .active(active), .hp(hp), .defeated(defeated)
  );

  typedef struct {
    int x; int y; int act; int hp; int dfd; int isp; int addr;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;

  // Reference model: event-level description of the boss behaviour.
  int m_cnt, m_x, m_y, m_idx, m_hp, m_flash_left, m_ticks;
  bit m_app, m_enter, m_dead, m_pend, m_valid;
  int PAT[8] = '{-36, 0, 16, -48, 36, 0, -16, 48};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int wrap10(input int v);
    return ((v % 1024) + 1024) % 1024;
  endfunction

  function automatic void m_reset();
    m_cnt = 0; m_x = 370; m_y = 290; m_idx = 0; m_hp = HP0;
    m_flash_left = 0; m_app = 0; m_enter = 0; m_dead = 0; m_pend = 0;
  endfunction

  function automatic bit m_in_patrol();
    return m_app && !m_enter && !m_dead && (m_flash_left == 0);
  endfunction

  function automatic int m_active();
    if (!m_app || m_dead) return 0;
    if (m_flash_left == 0) return 1;
    return ((FL - m_flash_left) % 2 == 1) ? 1 : 0;
  endfunction

  function automatic int m_scroll(input logic [31:0] k, input int bg);
    bit l, r;
    logic [31:0] kk;
    l = 0; r = 0; kk = k;
    for (int i = 0; i < 4; i++) begin
      if (kk[8*i +: 8] == 8'h04) l = 1;
      if (kk[8*i +: 8] == 8'h07) r = 1;
    end
    if (bg < 270 || bg > 320) return 0;
    if (l && !r) return 80;
    if (r && !l) return -80;
    return 0;
  endfunction

  task automatic m_clock(input bit rst, input bit drst, input logic [31:0] k,
                         input int bg, input bit h);
    bit tk, hitnow;
    int sc;
    if (rst || drst) begin
      m_reset();
      m_valid = 1;
      return;
    end
    tk = (m_cnt == TD - 1);
    m_cnt = tk ? 0 : m_cnt + 1;
    if (!tk) begin
      if (h && m_in_patrol()) m_pend = 1;
      return;
    end
    m_ticks++;
    hitnow = m_pend || (h && m_in_patrol());
    m_pend = 0;
    sc = m_scroll(k, bg);
    if (m_dead) begin
    end else if (!m_app) begin
      if (bg > 280 && bg < 360) begin
        m_app = 1; m_enter = 1; m_y = 270;
      end
    end else if (bg > 360) begin
      m_app = 0; m_enter = 0; m_flash_left = 0; m_x = 370; m_y = 290;
    end else if (m_enter) begin
      m_y = wrap10(m_y + 20); m_x = wrap10(m_x + sc); m_idx = 0; m_enter = 0;
    end else begin
      m_x = wrap10(m_x + PAT[m_idx] + sc);
      m_idx = (m_idx + 1) % 8;
      if (m_flash_left > 0) m_flash_left--;
      else if (hitnow) begin
        m_hp--;
        if (m_hp == 0) m_dead = 1;
        else m_flash_left = FL;
      end
    end
  endtask

  function automatic void push_exp(input int dx, input int dy);
    exp_t e;
    e.x = m_x; e.y = m_y; e.act = m_active(); e.hp = m_hp; e.dfd = m_dead;
    e.isp = (e.act == 1 && dx >= m_x && dy >= m_y && dx - m_x < 130 && dy - m_y < 130) ? 1 : 0;
    e.addr = e.isp ? (((dx - m_x) >> 1) + 123 + ((dy - m_y) >> 1) * 188) : 0;
    q.push_back(e);
  endfunction

  function automatic int rdx();
    return wrap10(m_x + int'($urandom_range(0, 145)) - 5);
  endfunction

  function automatic int rdy();
    return wrap10(m_y + int'($urandom_range(0, 145)) - 5);
  endfunction

  // Called at posedge+1; holds inputs for one cycle and advances the model.
  task automatic cyc(input bit rst, input bit drst, input logic [31:0] k, input int bg,
                     input int dx, input int dy, input bit h);
    Reset = rst; dead_reset = drst; keycode = k; BG_step = bg[8:0];
    DrawX = dx[9:0]; DrawY = dy[9:0]; hit = h;
    if (m_valid) push_exp(dx, dy);
    @(posedge Clk);
    m_clock(rst, drst, k, bg, h);
    #1;
  endtask

  task automatic tick_with(input logic [31:0] k, input int bg, input bit h_on_tick,
                           input bit drst_on_tick);
    int guard;
    guard = 0;
    while (m_cnt != TD - 1 && guard < 4 * TD) begin
      cyc(0, 0, k, bg, rdx(), rdy(), 0);
      guard++;
    end
    chk("tick_wait", m_cnt, TD - 1);
    cyc(0, drst_on_tick, k, bg, rdx(), rdy(), h_on_tick);
  endtask

  // Zero-clock pixel probe; at most three per cycle so the scoreboard stays aligned.
  task automatic pix(input string nm, input int dx, input int dy, input int e_isp, input int e_addr);
    DrawX = dx[9:0]; DrawY = dy[9:0];
    #1;
    chk({nm, "_isp"}, {31'b0, is_sprite}, e_isp);
    chk({nm, "_addr"}, {13'b0, sprite_addr}, e_addr);
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_x", {22'b0, sprite_x}, e.x);
      chk("sb_y", {22'b0, sprite_y}, e.y);
      chk("sb_active", {31'b0, active}, e.act);
      chk("sb_hp", {28'b0, hp}, e.hp);
      chk("sb_defeated", {31'b0, defeated}, e.dfd);
      chk("sb_is_sprite", {31'b0, is_sprite}, e.isp);
      chk("sb_addr", {13'b0, sprite_addr}, e.addr);
    end
  end

  initial begin
    #500_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int xseq[8] = '{334, 334, 350, 302, 338, 338, 322, 370};
  int aseq[5] = '{0, 1, 0, 1, 1};
  logic [31:0] keys[8] = '{32'h0, 32'h04, 32'h07, 32'h0704, 32'h04000000,
                           32'h00070000, 32'h1A2B3C4D, 32'h07000004};

  initial begin
    int rbg;
    m_valid = 0; m_ticks = 0;
    m_reset();
    @(posedge Clk); #1;

    // Reset state
    cyc(1, 0, 0, 300, 0, 0, 0);
    cyc(1, 0, 0, 300, 0, 0, 0);
    chk("rst_x", {22'b0, sprite_x}, 370);
    chk("rst_y", {22'b0, sprite_y}, 290);
    chk("rst_active", {31'b0, active}, 0);
    chk("rst_hp", {28'b0, hp}, HP0);
    chk("rst_defeated", {31'b0, defeated}, 0);

    // Entry and patrol pattern
    tick_with(0, 300, 0, 0);
    chk("enter_y", {22'b0, sprite_y}, 270);
    chk("enter_active", {31'b0, active}, 1);
    tick_with(0, 300, 0, 0);
    chk("land_y", {22'b0, sprite_y}, 290);
    chk("land_x", {22'b0, sprite_x}, 370);
    for (int i = 0; i < 8; i++) begin
      tick_with(0, 300, 0, 0);
      chk("pat_x", {22'b0, sprite_x}, xseq[i]);
      chk("pat_active", {31'b0, active}, 1);
    end

    // Scroll compensation
    tick_with(0, 300, 0, 0);
    chk("scroll_none_x", {22'b0, sprite_x}, 334);
    tick_with(32'h04, 300, 0, 0);
    chk("scroll_left_x", {22'b0, sprite_x}, 414);
    tick_with(32'h0704, 300, 0, 0);
    chk("scroll_both_x", {22'b0, sprite_x}, 430);
    tick_with(32'h07, 330, 0, 0);
    chk("scroll_outside_x", {22'b0, sprite_x}, 382);
    for (int i = 0; i < 4; i++) tick_with(0, 300, 0, 0);
    chk("cycle_end_x", {22'b0, sprite_x}, 450);

    // Hits to defeat
    cyc(0, 0, 0, 300, rdx(), rdy(), 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) cyc(0, 0, 0, 300, rdx(), rdy(), 1);
      tick_with(0, 300, 0, 0);
      chk("flash1_active", {31'b0, active}, aseq[i]);
      chk("flash1_hp", {28'b0, hp}, 2);
    end
    tick_with(0, 300, 1, 0);
    chk("hit_on_tick_hp", {28'b0, hp}, 1);
    chk("hit_on_tick_active", {31'b0, active}, 0);
    for (int i = 0; i < 4; i++) tick_with(0, 300, 0, 0);
    chk("flash2_end_active", {31'b0, active}, 1);
    cyc(0, 0, 0, 300, rdx(), rdy(), 1);
    tick_with(0, 300, 0, 0);
    chk("dead_hp", {28'b0, hp}, 0);
    chk("dead_defeated", {31'b0, defeated}, 1);
    chk("dead_active", {31'b0, active}, 0);
    pix("dead_px0", m_x, m_y, 0, 0);
    pix("dead_px1", wrap10(m_x + 64), wrap10(m_y + 64), 0, 0);
    cyc(0, 0, 0, 300, rdx(), rdy(), 1);
    tick_with(0, 300, 1, 0);
    tick_with(0, 370, 0, 0);
    chk("dead_sticky", {31'b0, defeated}, 1);
    chk("dead_hp_sticky", {28'b0, hp}, 0);

    // Pixel/address, then retreat
    cyc(1, 0, 0, 300, 0, 0, 0);
    tick_with(0, 300, 0, 0);
    tick_with(0, 300, 0, 0);
    pix("px_origin", 370, 290, 1, 123);
    pix("px_corner", 499, 419, 1, 12219);
    pix("px_right_out", 500, 290, 0, 0);
    cyc(0, 0, 0, 300, rdx(), rdy(), 0);
    pix("px_left_out", 369, 290, 0, 0);
    pix("px_below_out", 370, 420, 0, 0);
    pix("px_right_edge", 499, 290, 1, 187);
    cyc(0, 0, 0, 300, rdx(), rdy(), 0);
    tick_with(0, 300, 0, 0);
    cyc(0, 0, 0, 300, rdx(), rdy(), 1);
    tick_with(0, 300, 0, 0);
    for (int i = 0; i < 5; i++) tick_with(0, 300, 0, 0);
    tick_with(0, 361, 0, 0);
    chk("retreat_x", {22'b0, sprite_x}, 370);
    chk("retreat_y", {22'b0, sprite_y}, 290);
    chk("retreat_active", {31'b0, active}, 0);
    chk("retreat_hp", {28'b0, hp}, 2);

    // dead_reset during flash, coincident with a tick
    tick_with(0, 300, 0, 0);
    tick_with(0, 300, 0, 0);
    cyc(0, 0, 0, 300, rdx(), rdy(), 1);
    tick_with(0, 300, 0, 0);
    tick_with(0, 300, 0, 0);
    tick_with(0, 300, 0, 1);
    chk("drst_x", {22'b0, sprite_x}, 370);
    chk("drst_y", {22'b0, sprite_y}, 290);
    chk("drst_active", {31'b0, active}, 0);
    chk("drst_hp", {28'b0, hp}, HP0);
    chk("drst_defeated", {31'b0, defeated}, 0);
    for (int i = 0; i < TD - 1; i++) cyc(0, 0, 0, 300, rdx(), rdy(), 0);
    chk("drst_no_early_tick", {31'b0, active}, 0);
    cyc(0, 0, 0, 300, rdx(), rdy(), 0);
    chk("drst_first_tick", {31'b0, active}, 1);
    chk("drst_first_tick_y", {22'b0, sprite_y}, 270);

    // Randomized traffic against the model
    rbg = 300;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 39) == 0) rbg = int'($urandom_range(260, 370));
      cyc($urandom_range(0, 1499) == 0, $urandom_range(0, 399) == 0,
          keys[$urandom_range(0, 7)], rbg, rdx(), rdy(), $urandom_range(0, 9) == 0);
    end

    @(negedge Clk);
    #1;
    chk("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
